// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard sequencer bundle: ID/EX/MEM hazard inputs and stall/flush/status outputs.
// The master is the datapath; the slave is hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             id_branch_taken;
  logic             id_uses_hilo;
  logic             id_halt;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [4:0]       ex_dest;
  logic             mem_mem_read;
  logic [4:0]       mem_dest;
  logic             ex_md_start;
  logic             pc_write;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             md_busy;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken,
           id_uses_hilo, id_halt, ex_mem_read, ex_reg_write, ex_dest, mem_mem_read,
           mem_dest, ex_md_start,
    input  pc_write, if_id_stall, if_id_flush, id_ex_flush, md_busy, halted, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken,
           id_uses_hilo, id_halt, ex_mem_read, ex_reg_write, ex_dest, mem_mem_read,
           mem_dest, ex_md_start,
    output pc_write, if_id_stall, if_id_flush, id_ex_flush, md_busy, halted, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: hazard stalls, branch flush, mult/div busy
// tracking, halt drain and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY   = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave bus
);

  localparam int unsigned MdW = $clog2(MD_LATENCY + 1);
  localparam int unsigned DrW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e           r_state;
  logic [MdW-1:0]   r_md_cnt;
  logic [DrW-1:0]   r_drain_cnt;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_match_ex, w_match_mem;
  logic w_load_use, w_br_haz, w_md_busy, w_md_haz, w_stall;

  // Register 0 is hardwired, so a write to it can never create a dependency.
  assign w_match_ex  = (bus.ex_dest != 5'd0) &&
                       ((bus.id_uses_rs && (bus.ex_dest == bus.id_rs)) ||
                        (bus.id_uses_rt && (bus.ex_dest == bus.id_rt)));
  assign w_match_mem = (bus.mem_dest != 5'd0) &&
                       ((bus.id_uses_rs && (bus.mem_dest == bus.id_rs)) ||
                        (bus.id_uses_rt && (bus.mem_dest == bus.id_rt)));

  assign w_load_use = bus.ex_mem_read && w_match_ex;
  assign w_br_haz   = bus.id_is_branch &&
                      ((bus.ex_reg_write && w_match_ex) || (bus.mem_mem_read && w_match_mem));
  assign w_md_busy  = (r_md_cnt != '0);
  assign w_md_haz   = w_md_busy && bus.id_uses_hilo;
  assign w_stall    = w_load_use || w_br_haz || w_md_haz;

  assign bus.md_busy      = w_md_busy;
  assign bus.halted       = (r_state == StHalted);
  assign bus.stall_cycles = r_stall_cycles;

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.if_id_stall = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;
    unique case (r_state)
      StRun: begin
        // A taken branch under a stall is dropped: its operands are not yet valid.
        if (w_stall || bus.id_halt) begin
          bus.pc_write    = 1'b0;
          bus.if_id_stall = 1'b1;
          bus.id_ex_flush = 1'b1;
        end else if (bus.id_branch_taken) begin
          bus.if_id_flush = 1'b1;
        end
      end
      default: begin
        bus.pc_write    = 1'b0;
        bus.if_id_stall = 1'b1;
        bus.id_ex_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StRun;
      r_md_cnt       <= '0;
      r_drain_cnt    <= '0;
      r_stall_cycles <= '0;
    end else begin
      // A start pulse while the unit is still busy does not extend the window.
      if (bus.ex_md_start && !w_md_busy) begin
        r_md_cnt <= MdW'(MD_LATENCY);
      end else if (w_md_busy) begin
        r_md_cnt <= r_md_cnt - MdW'(1);
      end

      if ((r_state == StRun) && w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end

      unique case (r_state)
        StRun: begin
          if (!w_stall && bus.id_halt) begin
            r_state     <= StDrain;
            r_drain_cnt <= DrW'(DRAIN_CYCLES);
          end
        end
        StDrain: begin
          if (r_drain_cnt != '0) begin
            r_drain_cnt <= r_drain_cnt - DrW'(1);
          end
          if (!w_md_busy && (r_drain_cnt <= DrW'(1))) begin
            r_state <= StHalted;
          end
        end
        default: r_state <= StHalted;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hazard decode, branch flush, mult/div window, halt drain,
// reset recovery, and counter saturation on a narrow-counter instance.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) bus ();
  hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  hazard_ctrl #(.MD_LATENCY(4), .DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  hazard_ctrl #(.MD_LATENCY(4), .DRAIN_CYCLES(3), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  // {pc_write, if_id_stall, if_id_flush, id_ex_flush}
  logic [3:0] ctl, ctl4;
  assign ctl  = {bus.pc_write, bus.if_id_stall, bus.if_id_flush, bus.id_ex_flush};
  assign ctl4 = {bus4.pc_write, bus4.if_id_stall, bus4.if_id_flush, bus4.id_ex_flush};

  localparam logic [3:0] CtlRun   = 4'b1000;
  localparam logic [3:0] CtlStall = 4'b0101;
  localparam logic [3:0] CtlFlush = 4'b1010;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs = 5'd0;  bus.id_rt = 5'd0;  bus.id_uses_rs = 1'b0;  bus.id_uses_rt = 1'b0;
    bus.id_is_branch = 1'b0;  bus.id_branch_taken = 1'b0;  bus.id_uses_hilo = 1'b0;
    bus.id_halt = 1'b0;  bus.ex_mem_read = 1'b0;  bus.ex_reg_write = 1'b0;
    bus.ex_dest = 5'd0;  bus.mem_mem_read = 1'b0;  bus.mem_dest = 5'd0;
    bus.ex_md_start = 1'b0;
  endtask

  task automatic idle4();
    bus4.id_rs = 5'd0;  bus4.id_rt = 5'd0;  bus4.id_uses_rs = 1'b0;  bus4.id_uses_rt = 1'b0;
    bus4.id_is_branch = 1'b0;  bus4.id_branch_taken = 1'b0;  bus4.id_uses_hilo = 1'b0;
    bus4.id_halt = 1'b0;  bus4.ex_mem_read = 1'b0;  bus4.ex_reg_write = 1'b0;
    bus4.ex_dest = 5'd0;  bus4.mem_mem_read = 1'b0;  bus4.mem_dest = 5'd0;
    bus4.ex_md_start = 1'b0;
  endtask

  initial begin
    idle();
    idle4();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_ctl", 32'(ctl), 32'(CtlRun));
    chk("reset_md_busy", 32'(bus.md_busy), 32'd0);
    chk("reset_halted", 32'(bus.halted), 32'd0);
    chk("reset_cnt", bus.stall_cycles, 32'd0);
    chk("reset_cnt4", 32'(bus4.stall_cycles), 32'd0);

    // Load-use on rs
    bus.ex_mem_read = 1'b1;  bus.ex_dest = 5'd8;  bus.id_rs = 5'd8;  bus.id_uses_rs = 1'b1;
    #1;
    chk("lu_ctl", 32'(ctl), 32'(CtlStall));
    chk("lu_cnt_before", bus.stall_cycles, 32'd0);
    tick();
    chk("lu_cnt_after", bus.stall_cycles, 32'd1);
    bus.ex_dest = 5'd0;  bus.id_rs = 5'd0;
    #1;
    chk("lu_r0_ctl", 32'(ctl), 32'(CtlRun));
    tick();
    chk("lu_r0_cnt", bus.stall_cycles, 32'd1);

    // EX write hazard matters only for branches resolved in ID
    idle();
    bus.ex_reg_write = 1'b1;  bus.ex_dest = 5'd8;  bus.id_rt = 5'd8;  bus.id_uses_rt = 1'b1;
    #1;
    chk("exw_nobr_ctl", 32'(ctl), 32'(CtlRun));
    bus.id_is_branch = 1'b1;
    #1;
    chk("exw_br_ctl", 32'(ctl), 32'(CtlStall));

    // Taken branch flush, then branch-operand hazard from a MEM load
    idle();
    bus.id_branch_taken = 1'b1;
    #1;
    chk("br_flush_ctl", 32'(ctl), 32'(CtlFlush));
    bus.id_is_branch = 1'b1;  bus.mem_mem_read = 1'b1;  bus.mem_dest = 5'd5;  bus.id_rt = 5'd5;
    #1;
    chk("br_rt_unused_ctl", 32'(ctl), 32'(CtlFlush));
    bus.id_uses_rt = 1'b1;
    #1;
    chk("br_haz_ctl", 32'(ctl), 32'(CtlStall));
    tick();
    chk("br_haz_cnt", bus.stall_cycles, 32'd2);

    // Mult/div busy window with a HI/LO consumer waiting in ID
    idle();
    bus.ex_md_start = 1'b1;  bus.id_uses_hilo = 1'b1;
    #1;
    chk("md_pre_ctl", 32'(ctl), 32'(CtlRun));
    tick();
    bus.ex_md_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("md_busy_c%0d", i), 32'(bus.md_busy), 32'd1);
      chk($sformatf("md_ctl_c%0d", i), 32'(ctl), 32'(CtlStall));
      bus.ex_md_start = (i == 2);
      tick();
    end
    bus.ex_md_start = 1'b0;
    #1;
    chk("md_release_busy", 32'(bus.md_busy), 32'd0);
    chk("md_release_ctl", 32'(ctl), 32'(CtlRun));
    chk("md_cnt", bus.stall_cycles, 32'd6);

    // Halt drain; hazards and branches during drain are ignored and not counted
    idle();
    bus.id_halt = 1'b1;
    #1;
    chk("halt_issue_ctl", 32'(ctl), 32'(CtlStall));
    tick();
    bus.id_branch_taken = 1'b1;
    bus.ex_mem_read = 1'b1;  bus.ex_dest = 5'd9;  bus.id_rs = 5'd9;  bus.id_uses_rs = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk($sformatf("drain_ctl_c%0d", i), 32'(ctl), 32'(CtlStall));
      chk($sformatf("drain_halted_c%0d", i), 32'(bus.halted), 32'd0);
      tick();
    end
    chk("halted", 32'(bus.halted), 32'd1);
    chk("halted_ctl", 32'(ctl), 32'(CtlStall));
    tick();
    tick();
    chk("halted_hold", 32'(bus.halted), 32'd1);
    chk("halted_cnt", bus.stall_cycles, 32'd6);

    // Reset out of HALTED
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_halt_halted", 32'(bus.halted), 32'd0);
    chk("rst_halt_ctl", 32'(ctl), 32'(CtlRun));
    chk("rst_halt_cnt", bus.stall_cycles, 32'd0);

    // Halt while mult/div is busy: two extra drain cycles until the unit frees up
    bus.id_halt = 1'b1;  bus.ex_md_start = 1'b1;
    tick();
    idle();
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk($sformatf("mdrain_halted_c%0d", i), 32'(bus.halted), 32'd0);
      chk($sformatf("mdrain_busy_c%0d", i), 32'(bus.md_busy), 32'(i <= 4));
      tick();
    end
    chk("mdrain_halted", 32'(bus.halted), 32'd1);

    // Reset during DRAIN with mult/div busy and a nonzero stall count
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.ex_mem_read = 1'b1;  bus.ex_dest = 5'd3;  bus.id_rt = 5'd3;  bus.id_uses_rt = 1'b1;
    tick();
    idle();
    bus.id_halt = 1'b1;  bus.ex_md_start = 1'b1;
    tick();
    idle();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_drain_ctl", 32'(ctl), 32'(CtlRun));
    chk("rst_drain_halted", 32'(bus.halted), 32'd0);
    chk("rst_drain_busy", 32'(bus.md_busy), 32'd0);
    chk("rst_drain_cnt", bus.stall_cycles, 32'd0);
    tick();
    tick();
    tick();
    chk("rst_drain_stays_run", 32'(bus.halted), 32'd0);

    // 4-bit counter saturates at 15
    bus4.ex_mem_read = 1'b1;  bus4.ex_dest = 5'd12;  bus4.id_rs = 5'd12;
    bus4.id_uses_rs = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) chk("sat_cnt_10", 32'(bus4.stall_cycles), 32'd10);
    end
    chk("sat_cnt_20", 32'(bus4.stall_cycles), 32'd15);
    chk("sat_ctl", 32'(ctl4), 32'(CtlStall));
    idle4();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Detects data hazards (load-use, and branch-operand hazards on branches resolved in ID).
- Tracks the busy window of the multi-cycle mult/div unit and sequences the halt drain.
- Drives stall/flush of the IF/ID latch, bubble insertion into ID/EX, and PC write enable. Provides a saturating stall-cycle counter for debug.

Parameters:
- MD_LATENCY, 4, cycles the mult/div unit stays busy after ex_md_start.
- DRAIN_CYCLES, 3, cycles needed to retire instructions ahead of HALT (EX, MEM, WB).
- CNT_W, 32, width of stall_cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_branch  in  1  ID holds a branch resolved in ID.
- id_branch_taken  in  1  branch/jump in ID redirects PC.
- id_uses_hilo  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO or MULT/DIV.
- id_halt  in  1  ID holds HALT.
- ex_mem_read  in  1  EX instruction is a load.
- ex_reg_write  in  1  EX instruction writes a GPR.
- ex_dest  in  5  EX destination register.
- mem_mem_read  in  1  MEM instruction is a load.
- mem_dest  in  5  MEM destination register.
- ex_md_start  in  1  mult/div entered EX this cycle (pulse).
- pc_write  out  1  PC register load enable.
- if_id_stall  out  1  hold IF/ID latch.
- if_id_flush  out  1  clear IF/ID latch.
- id_ex_flush  out  1  insert bubble into ID/EX.
- md_busy  out  1  mult/div unit busy.
- halted  out  1  core halted.
- stall_cycles  out  CNT_W  count of cycles with hazard stall asserted.

Behaviour:
- match(d): d != 0 && ((id_uses_rs && d == id_rs) || (id_uses_rt && d == id_rt)). Register 0 never matches.
- Hazard terms:
  - load_use = ex_mem_read && match(ex_dest).
  - br_haz = id_is_branch && ((ex_reg_write && match(ex_dest)) || (mem_mem_read && match(mem_dest))).
  - md_haz = md_busy && id_uses_hilo.
  - stall = load_use || br_haz || md_haz.
- State machine, registered, states RUN, DRAIN, HALTED. Reset → RUN.
- RUN with stall: pc_write=0, if_id_stall=1, id_ex_flush=1, if_id_flush=0. A simultaneous id_branch_taken is ignored because operands are not valid.
- RUN, no stall, id_branch_taken=1: pc_write=1, if_id_flush=1, if_id_stall=0, id_ex_flush=0.
- RUN, no stall, id_halt=1: next state DRAIN, drain_cnt ← DRAIN_CYCLES. This cycle: pc_write=0, if_id_stall=1, id_ex_flush=1. HALT is held in ID and never issued. id_halt with stall stays in RUN (stall rules apply).
- RUN, otherwise: pc_write=1, all stall/flush outputs 0.
- DRAIN: pc_write=0, if_id_stall=1, id_ex_flush=1, if_id_flush=0. drain_cnt decrements each cycle, saturating at 0. When drain_cnt == 1 and md_busy == 0 (or drain_cnt == 0 and md_busy == 0) → HALTED next cycle. Branch inputs are ignored.
- HALTED: pc_write=0, if_id_stall=1, id_ex_flush=1, halted=1. Only reset exits.
- Stall/flush outputs are combinational from current state and inputs. halted and md_busy are decoded from registers.
- md counter (width clog2(MD_LATENCY+1)):
  - Reset → 0.
  - ex_md_start while counter == 0 loads MD_LATENCY.
  - Otherwise decrements if nonzero.
  - md_busy = (counter != 0). Busy for exactly MD_LATENCY cycles after the start edge.
  - ex_md_start while busy is ignored (no reload).
- stall_cycles: reset → 0. Increments on each clock where RUN && stall, saturating at all-ones. DRAIN/HALTED cycles are not counted.
- Reset values: pc_write=1, if_id_stall=0, if_id_flush=0, id_ex_flush=0, md_busy=0, halted=0, stall_cycles=0.
- Reset mid-DRAIN or in HALTED returns to RUN the next cycle, clearing all counters.

Test Plan:
- Load-use: ex_mem_read=1, ex_dest=8, id_rs=8, id_uses_rs=1 → pc_write=0, if_id_stall=1, id_ex_flush=1, stall_cycles 0→1. Same with ex_dest=0 → no stall.
- Branch flush vs stall: id_branch_taken=1, no hazards → if_id_flush=1, pc_write=1. Add id_is_branch=1, mem_mem_read=1, mem_dest=id_rt=5, id_uses_rt=1 → stall outputs asserted, if_id_flush=0.
- Mult/div: pulse ex_md_start → md_busy high exactly 4 cycles. id_uses_hilo=1 throughout → stall for those 4 cycles, released on the 5th. Second ex_md_start at busy cycle 2 does not extend the window.
- Halt: id_halt=1 in RUN → DRAIN for 3 cycles (pc_write=0, id_ex_flush=1), then halted=1 and held. Repeat with md_busy active: halted deferred until md_busy=0.
- Reset: assert reset in HALTED and during DRAIN → next cycle RUN, halted=0, pc_write=1, stall_cycles=0, md_busy=0.
- Saturation: with CNT_W=4, hold load-use 20 cycles → stall_cycles stops at 15.
